// File: rtl/regfile_pkg.sv
// Shared parameters, address typedef and the log2 helper for the register file.
package regfile_pkg;

    localparam int unsigned XLEN_D  = 32;
    localparam int unsigned NREGS_D = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned AW_D = clog2(NREGS_D);

    typedef logic [AW_D-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: writeback clears, issue sets, and the set wins on conflict.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_D,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        // Applied after the clears so a new producer supersedes the retiring one.
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: async reads with optional forwarding,
// prioritised synchronous writes, x0 hard-wired to zero, busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_D,
    parameter int unsigned NREGS  = NREGS_D,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    // Ascending port order: the highest-index port to the same address lands last.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                mem_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = mem_q[addr];
            busy = busy_vec[addr];
            if (BYPASS != 0) begin
                for (int unsigned w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] != '0) &&
                        (wr_addr[w*AW +: AW] == addr)) begin
                        data = wr_data[w*XLEN +: XLEN];
                        busy = 1'b0;
                    end
                end
            end
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = busy;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core and its pipelined successors. Provides NRD asynchronous read ports and NWR synchronous write ports, with optional write-to-read bypass and a per-register busy scoreboard for in-flight results. Register 0 is hard-wired to zero. Sits between decode (reads, issue) and writeback (writes).

## Interface
- XLEN, 32: data width in bits
- NREGS, 32: number of architectural registers, a power of two, at least 2
- NRD, 2: number of read ports, at least 1
- NWR, 2: number of write ports, at least 1
- BYPASS, 1: 1 forwards same-cycle write data to read ports; 0 disables forwarding
- AW is derived as log2(NREGS) and is not overridable

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses, port k in slice k
- rd_data  out  NRD*XLEN  read data
- rd_busy  out  NRD  addressed register has a pending producer
- wr_en  in  NWR  write strobes
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  marks the register at iss_addr as pending
- iss_addr  in  AW  destination register of the issued instruction
- busy_vec  out  NREGS  full scoreboard, bit i set when register i is pending

## Operation
- Reset: while rst is 0 at a rising edge, all registers clear to 0 and all busy bits clear. Writes and issues in that cycle are ignored.
- Read path is combinational. rd_data[k] = 0 when rd_addr[k] = 0. Otherwise it is the forwarded value (below), else the stored value.
- Forwarding (BYPASS=1 only): if any enabled write port with a non-zero address matches rd_addr[k], rd_data[k] takes that port's wr_data.
- Write: at each edge, each enabled port with wr_addr ≠ 0 updates its register. Writes to address 0 are discarded.
- Write collision: if several enabled ports target the same address, the highest-index port wins. The same priority applies to forwarding.
- Scoreboard, clear: an enabled write with a non-zero address clears busy[wr_addr] at the edge.
- Scoreboard, set: iss_en with iss_addr ≠ 0 sets busy[iss_addr] at the edge.
- Issue and writeback to the same register in one cycle: the set wins, because the new producer supersedes the old one.
- busy[0] is constant 0.
- rd_busy[k] = busy[rd_addr[k]], masked to 0 when BYPASS=1 and a same-cycle write to that address is forwarded.
- busy_vec reports the registered state only; it has no bypass masking.

## Timing
- Read latency: 0 cycles (combinational) from rd_addr.
- Write-to-read visibility: 0 cycles with BYPASS=1; with BYPASS=0, visible from the cycle after the write edge.
- Issue-to-busy: busy_vec and rd_busy assert in the cycle after the iss_en edge.
- Writeback-to-clear: busy bit drops in the cycle after the write edge. With BYPASS=1, rd_busy drops in the write cycle itself.
- Reset values: all registers 0; busy_vec all 0; rd_data 0 and rd_busy 0 for every address, unless a write is being forwarded with BYPASS=1.
- Reset asserted mid-operation: pending busy bits are lost. The issuing pipeline must be flushed alongside.

## Structure
- Package regfile_pkg holds:
  - the clog2 helper and the AW derivation
  - defaults XLEN_D=32 and NREGS_D=32
  - a typedef for the register address
- Sub-module regfile_scoreboard (NREGS, NWR) holds the busy vector, its set/clear/priority logic and reset. regfile_mp instantiates it once.
- The storage array and the forwarding muxes stay in regfile_mp.

## Test plan
- Reset, then read addresses 0, 5 and 31 on all ports -> rd_data = 0, busy_vec = 0.
- Write 0xDEADBEEF to x5 on port 0 with BYPASS=1, reading x5 in the same cycle -> rd_data = 0xDEADBEEF that cycle and after. With BYPASS=0, the old value 0 that cycle and 0xDEADBEEF next cycle.
- Ports 0 and 1 both write x7, with 0x11 and 0x22 -> stored and forwarded value is 0x22. A write of 0xFF to x0 -> x0 still reads 0.
- Issue x3 -> busy_vec[3] = 1 and rd_busy = 1 next cycle. Write x3 -> busy clears the next cycle. Issue and write x3 in the same cycle -> busy_vec[3] stays 1.
- Issue x9 and write x4 = 0x1234, then assert rst for one cycle -> all registers read 0 and busy_vec = 0.
- Randomised writes over NREGS=16, NWR=3, NRD=4, checked against a reference model for 10k cycles -> no mismatch.
